tile_scheduler: RTL and testbench
=================================

Name: tile_scheduler

Overview:
- Sits directly downstream of the layer decoder. Consumes the registered layer parameters on a start pulse.
- Walks the layer's tile iteration space: output-channel tiles × output-pixel chunks × input-channel tiles.
- Issues one tile descriptor per valid/ready handshake to the DMA/PE-array controller.
- Flags the first and last input-channel tile of each accumulation so downstream logic can clear partial sums or write them back.

Parameters:
- CH_W, 11, channel count/index width (matches in_D/out_K).
- PIX_W, 14, output-pixel count/index width (max 127*127 = 16129).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start_i  in  1  one-cycle pulse; latches all *_i parameters
- layer_type_i  in  2  0=PW, 1=DW, 2=STD, 3=LIN
- in_D_i  in  CH_W  input channels
- out_K_i  in  CH_W  output channels
- tile_D_i  in  7  channels per D tile
- tile_K_i  in  7  channels per K tile
- tile_n_i  in  32  output pixels per chunk
- out_R_i  in  7  output rows
- out_C_i  in  7  output columns
- tile_valid_o  out  1  descriptor valid
- tile_ready_i  in  1  consumer accepts descriptor
- k_base_o  out  CH_W  first output channel of tile
- k_len_o  out  7  output channels in tile (edge-clipped)
- d_base_o  out  CH_W  first input channel of tile
- d_len_o  out  7  input channels in tile (edge-clipped)
- pix_base_o  out  PIX_W  first linear output pixel (row*out_C+col)
- pix_len_o  out  PIX_W  pixels in chunk (edge-clipped)
- first_d_o  out  1  first D tile of this (k, pix) accumulation
- last_d_o  out  1  last D tile of this (k, pix) accumulation
- last_tile_o  out  1  final tile of layer
- busy_o  out  1  scheduler active
- done_o  out  1  one-cycle pulse after last tile accepted
- err_o  out  1  sticky config error, cleared by next start

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States:
  - IDLE: on start_i, latch inputs, compute pix_total = out_R*out_C (PIX_W bits), go to RUN.
  - RUN: hold tile_valid_o=1.
  - DONE: done_o=1, busy_o=1, lasts one cycle, then IDLE.
- busy_o is 1 in RUN and DONE.
- start_i in RUN or DONE is ignored.
- Latency: start_i at cycle t gives tile_valid_o=1 with the first descriptor at t+1.
- Loop order, innermost first:
  - D: d_base += tile_D.
  - pixel chunk: pix_base += tile_n.
  - K: k_base += tile_K.
  - Each counter wraps to 0 when its next base reaches the total, carrying into the next loop.
- Advance only on tile_valid_o & tile_ready_i. While ready is low, all descriptor outputs stay stable.
- Clipping:
  - k_len = min(tile_K, out_K-k_base).
  - d_len = min(tile_D, in_D-d_base).
  - pix_len = min(tile_n, pix_total-pix_base).
  - tile_n_i values above pix_total clip to one chunk.
- DW layers (type 1): D loop has exactly one iteration. d_base_o = k_base_o and d_len_o = k_len_o; first_d_o = last_d_o = 1.
- first_d_o = (d_base==0). last_d_o = (d_base+tile_D >= in_D).
- last_tile_o is set on the descriptor where all three loops are at their final iteration. Its acceptance moves RUN to DONE; tile_valid_o drops the next cycle.
- Config error: at start, if any of in_D, out_K, tile_D, tile_K, tile_n, out_R, out_C is 0:
  - set err_o and go straight to DONE (done pulse at t+1, no tiles issued).
  - err_o clears on the next accepted start_i.
- Arithmetic: all base+step comparisons are computed one bit wider than the operands so they cannot overflow.
- Reset asserted mid-operation aborts immediately to IDLE with outputs at reset values.

Optional Feature:
- Macro TILE_SCHED_PERF_EN.
- With the macro:
  - Adds output tile_count_o (32 bits): tiles accepted since the last start_i.
  - Adds output stall_count_o (32 bits): cycles with tile_valid_o & !tile_ready_i.
  - Both counters clear on start_i, saturate at all-ones, and hold after done.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- PW, in_D=64, out_K=64, tile_D=tile_K=32, out 4x4, tile_n=8, ready=1:
  - 8 tiles, in order (k,pix,d) = (0,0,0), (0,0,32), (0,8,0), (0,8,32), (32,0,0), …
  - first_d/last_d alternate 1/0 and 0/1.
  - last_tile on the 8th tile; done at the cycle after the 8th handshake.
- Edge clip, in_D=40, out_K=20, tile 32, out 3x3, tile_n=4:
  - d_len sequence 32, 8; k_len=20.
  - pix_len sequence 4, 4, 1; 6 tiles total.
- DW, out_K=25, tile_K=10, out 2x2, tile_n=4:
  - 3 tiles with k_base 0, 10, 20 and k_len 10, 10, 5.
  - d_base equals k_base; first_d = last_d = 1 on every tile.
- Backpressure: hold ready=0 for 5 cycles mid-run:
  - descriptor outputs unchanged during the hold; no tile skipped or repeated.
  - stall_count=5 when TILE_SCHED_PERF_EN is defined.
- Config error: tile_n=0 at start → err_o=1, done_o pulses at t+1, tile_valid never asserts. A following valid start clears err_o.
- Reset mid-run after 3 tiles → all outputs 0, IDLE. A new start restarts the sequence from (0,0,0).

Source files
------------

// File: rtl/tile_scheduler.sv
// Tile iteration walker: issues (K tile, pixel chunk, D tile) descriptors, D innermost.
// Optional perf counters (tile_count_o, stall_count_o) under `TILE_SCHED_PERF_EN.
module tile_scheduler #(
  parameter int CH_W  = 11,
  parameter int PIX_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       layer_type_i,
  input  logic [CH_W-1:0]  in_D_i,
  input  logic [CH_W-1:0]  out_K_i,
  input  logic [6:0]       tile_D_i,
  input  logic [6:0]       tile_K_i,
  input  logic [31:0]      tile_n_i,
  input  logic [6:0]       out_R_i,
  input  logic [6:0]       out_C_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [CH_W-1:0]  k_base_o,
  output logic [6:0]       k_len_o,
  output logic [CH_W-1:0]  d_base_o,
  output logic [6:0]       d_len_o,
  output logic [PIX_W-1:0] pix_base_o,
  output logic [PIX_W-1:0] pix_len_o,
  output logic             first_d_o,
  output logic             last_d_o,
  output logic             last_tile_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]      tile_count_o,
  output logic [31:0]      stall_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic             dw_q, err_q;
  logic [CH_W-1:0]  in_d_q, out_k_q, k_base_q, k_base_d, d_base_q, d_base_d;
  logic [6:0]       tile_d_q, tile_k_q;
  logic [PIX_W-1:0] step_n_q, pix_tot_q, pix_base_q, pix_base_d;

  logic             accept, cfg_bad, fire;
  logic [PIX_W-1:0] pix_tot_in, step_in;

  assign accept     = start_i && (state_q == IDLE);
  assign cfg_bad    = (in_D_i == '0) || (out_K_i == '0) || (tile_D_i == '0) || (tile_K_i == '0) ||
                      (tile_n_i == '0) || (out_R_i == '0) || (out_C_i == '0);
  assign pix_tot_in = PIX_W'(out_R_i) * PIX_W'(out_C_i);
  // A chunk larger than the whole pixel space collapses to a single chunk.
  assign step_in    = (tile_n_i > 32'(pix_tot_in)) ? pix_tot_in : tile_n_i[PIX_W-1:0];

  // Loop-end tests carry one extra bit so base+step never wraps.
  logic [CH_W:0]    d_nxt, k_nxt;
  logic [PIX_W:0]   p_nxt;
  logic             d_last, k_last, p_last;
  logic [CH_W-1:0]  k_rem, d_rem;
  logic [PIX_W-1:0] p_rem;
  logic [6:0]       k_len, d_len;
  logic [PIX_W-1:0] p_len;

  assign d_nxt  = {1'b0, d_base_q} + (CH_W+1)'(tile_d_q);
  assign k_nxt  = {1'b0, k_base_q} + (CH_W+1)'(tile_k_q);
  assign p_nxt  = {1'b0, pix_base_q} + {1'b0, step_n_q};
  assign d_last = dw_q || (d_nxt >= {1'b0, in_d_q});
  assign k_last = k_nxt >= {1'b0, out_k_q};
  assign p_last = p_nxt >= {1'b0, pix_tot_q};
  assign k_rem  = out_k_q - k_base_q;
  assign d_rem  = in_d_q - d_base_q;
  assign p_rem  = pix_tot_q - pix_base_q;
  assign k_len  = (k_rem < CH_W'(tile_k_q)) ? k_rem[6:0] : tile_k_q;
  assign d_len  = (d_rem < CH_W'(tile_d_q)) ? d_rem[6:0] : tile_d_q;
  assign p_len  = (p_rem < step_n_q) ? p_rem : step_n_q;
  assign fire   = tile_valid_o && tile_ready_i;

  always_comb begin
    tile_valid_o = 1'b0;
    k_base_o     = '0;
    k_len_o      = '0;
    d_base_o     = '0;
    d_len_o      = '0;
    pix_base_o   = '0;
    pix_len_o    = '0;
    first_d_o    = 1'b0;
    last_d_o     = 1'b0;
    last_tile_o  = 1'b0;
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == DONE);
    err_o        = err_q;
    if (state_q == RUN) begin
      tile_valid_o = 1'b1;
      k_base_o     = k_base_q;
      k_len_o      = k_len;
      d_base_o     = dw_q ? k_base_q : d_base_q;
      d_len_o      = dw_q ? k_len : d_len;
      pix_base_o   = pix_base_q;
      pix_len_o    = p_len;
      first_d_o    = dw_q || (d_base_q == '0);
      last_d_o     = d_last;
      last_tile_o  = d_last && p_last && k_last;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_base_d   = k_base_q;
    d_base_d   = d_base_q;
    pix_base_d = pix_base_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d    = cfg_bad ? DONE : RUN;
        k_base_d   = '0;
        d_base_d   = '0;
        pix_base_d = '0;
      end
      RUN: if (fire) begin
        if (!d_last) begin
          d_base_d = d_nxt[CH_W-1:0];
        end else begin
          d_base_d = '0;
          if (!p_last) begin
            pix_base_d = p_nxt[PIX_W-1:0];
          end else begin
            pix_base_d = '0;
            if (!k_last) k_base_d = k_nxt[CH_W-1:0];
            else begin
              k_base_d = '0;
              state_d  = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_base_q   <= '0;
      d_base_q   <= '0;
      pix_base_q <= '0;
      dw_q       <= 1'b0;
      err_q      <= 1'b0;
      in_d_q     <= '0;
      out_k_q    <= '0;
      tile_d_q   <= '0;
      tile_k_q   <= '0;
      step_n_q   <= '0;
      pix_tot_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_base_q   <= k_base_d;
      d_base_q   <= d_base_d;
      pix_base_q <= pix_base_d;
      if (accept) begin
        dw_q      <= (layer_type_i == 2'd1);
        err_q     <= cfg_bad;
        in_d_q    <= in_D_i;
        out_k_q   <= out_K_i;
        tile_d_q  <= tile_D_i;
        tile_k_q  <= tile_K_i;
        step_n_q  <= step_in;
        pix_tot_q <= pix_tot_in;
      end
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] tile_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else if (accept) begin
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && (tile_cnt_q != '1)) tile_cnt_q <= tile_cnt_q + 32'd1;
      if (tile_valid_o && !tile_ready_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign tile_count_o  = tile_cnt_q;
  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: a nested-loop model queues expected descriptors,
// a negedge monitor pops and compares them on every handshake.
module tb_tile_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, tile_ready_i = 1'b1;
  logic [1:0]  layer_type_i = '0;
  logic [10:0] in_D_i = '0, out_K_i = '0;
  logic [6:0]  tile_D_i = '0, tile_K_i = '0, out_R_i = '0, out_C_i = '0;
  logic [31:0] tile_n_i = '0;
  logic        tile_valid_o, first_d_o, last_d_o, last_tile_o, busy_o, done_o, err_o;
  logic [10:0] k_base_o, d_base_o;
  logic [6:0]  k_len_o, d_len_o;
  logic [13:0] pix_base_o, pix_len_o;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0] tile_count_o, stall_count_o;
`endif

  tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .layer_type_i(layer_type_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .tile_n_i(tile_n_i), .out_R_i(out_R_i), .out_C_i(out_C_i),
    .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
    .k_base_o(k_base_o), .k_len_o(k_len_o), .d_base_o(d_base_o), .d_len_o(d_len_o),
    .pix_base_o(pix_base_o), .pix_len_o(pix_len_o), .first_d_o(first_d_o),
    .last_d_o(last_d_o), .last_tile_o(last_tile_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
`ifdef TILE_SCHED_PERF_EN
    , .tile_count_o(tile_count_o), .stall_count_o(stall_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] kb; logic [6:0] kl; logic [10:0] db; logic [6:0] dl;
    logic [13:0] pb; logic [13:0] pl; logic fd; logic ld; logic lt;
  } desc_t;

  desc_t got, snap;
  desc_t sb[$];
  int checks = 0, errors = 0;

  assign got = {k_base_o, k_len_o, d_base_o, d_len_o, pix_base_o, pix_len_o,
                first_d_o, last_d_o, last_tile_o};

  always @(negedge clk) begin
    if (rst_n && tile_valid_o && tile_ready_i) begin
      desc_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_tile: got %h exp none", got);
      end else begin
        e = sb.pop_front();
        assert (got === e) else begin
          errors++;
          $error("FAIL tile: got %h exp %h", got, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain nested loops, K outer, pixel chunk middle, D inner.
  task automatic gen(input int ty, input int inD, input int outK, input int tD, input int tK,
                     input int tn, input int R, input int C);
    desc_t e;
    int pt, step, kl, dl;
    pt = R * C;
    step = (tn > pt) ? pt : tn;
    for (int k = 0; k < outK; k += tK)
      for (int p = 0; p < pt; p += step) begin
        kl = (outK - k < tK) ? outK - k : tK;
        e = '0;
        e.kb = 11'(k); e.kl = 7'(kl);
        e.pb = 14'(p); e.pl = 14'((pt - p < step) ? pt - p : step);
        if (ty == 1) begin
          e.db = 11'(k); e.dl = 7'(kl); e.fd = 1'b1; e.ld = 1'b1;
          sb.push_back(e);
        end else begin
          for (int d = 0; d < inD; d += tD) begin
            dl = (inD - d < tD) ? inD - d : tD;
            e.db = 11'(d); e.dl = 7'(dl);
            e.fd = (d == 0); e.ld = (d + tD >= inD);
            sb.push_back(e);
          end
        end
      end
    e = sb.pop_back();
    e.lt = 1'b1;
    sb.push_back(e);
  endtask

  task automatic set_cfg(input int ty, input int inD, input int outK, input int tD, input int tK,
                         input int tn, input int R, input int C);
    layer_type_i = 2'(ty); in_D_i = 11'(inD); out_K_i = 11'(outK);
    tile_D_i = 7'(tD); tile_K_i = 7'(tK); tile_n_i = 32'(tn);
    out_R_i = 7'(R); out_C_i = 7'(C);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic start_layer(input int ty, input int inD, input int outK, input int tD,
                             input int tK, input int tn, input int R, input int C);
    set_cfg(ty, inD, outK, tD, tK, tn, R, C);
    gen(ty, inD, outK, tD, tK, tn, R, C);
    pulse_start();
  endtask

  task automatic wait_left(input int left);
    int n = 0;
    while (sb.size() > left && n < 1000) begin @(posedge clk); #2; n++; end
    chk("wait_tiles", 128'(sb.size() > left), 128'(0));
  endtask

  task automatic drain(input string tag);
    wait_left(0);
    chk({tag, "_done"}, 128'({done_o, busy_o, tile_valid_o}), 128'(3'b110));
    @(posedge clk); #2;
    chk({tag, "_idle"}, 128'({done_o, busy_o, tile_valid_o}), 128'(3'b000));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {58'(0), tile_valid_o, busy_o, done_o, err_o, first_d_o, last_d_o, last_tile_o, got},
        128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outs("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("idle_after_reset", 128'({tile_valid_o, busy_o, done_o}), 128'(0));

    start_layer(0, 64, 64, 32, 32, 8, 4, 4);
    chk("first_valid_t1", 128'({tile_valid_o, busy_o}), 128'(2'b11));
    drain("pw");

    start_layer(0, 40, 20, 32, 32, 4, 3, 3);
    drain("edge");

    start_layer(1, 25, 25, 10, 10, 4, 2, 2);
    drain("dw");

    start_layer(3, 16, 16, 16, 16, 1000, 3, 3);
    drain("lin_clip_n");

    // Backpressure after 3 tiles; a start pulse during the hold must be ignored.
    start_layer(0, 64, 64, 32, 32, 8, 4, 4);
    wait_left(5);
    tile_ready_i = 1'b0;
    snap = got;
    for (int i = 0; i < 5; i++) begin
      in_D_i = 11'd7; tile_n_i = '0;
      start_i = (i == 2);
      @(posedge clk); #2;
      chk("hold_stable", 128'(got), 128'(snap));
    end
    start_i = 1'b0;
    tile_ready_i = 1'b1;
    chk("no_err_mid_start", 128'(err_o), 128'(0));
    drain("bp");
`ifdef TILE_SCHED_PERF_EN
    chk("stall_count", 128'(stall_count_o), 128'(5));
    chk("tile_count", 128'(tile_count_o), 128'(8));
`endif

    set_cfg(0, 8, 8, 8, 8, 0, 2, 2);
    pulse_start();
    chk("cfg_err_t1", 128'({done_o, busy_o, err_o, tile_valid_o}), 128'(4'b1110));
    @(posedge clk); #2;
    chk("cfg_err_t2", 128'({done_o, busy_o, err_o, tile_valid_o}), 128'(4'b0010));
    start_layer(0, 8, 8, 8, 8, 4, 2, 2);
    chk("err_cleared", 128'(err_o), 128'(0));
    drain("after_err");

    start_layer(2, 64, 64, 32, 32, 8, 4, 4);
    wait_left(5);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrun_reset");
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    start_layer(2, 64, 64, 32, 32, 8, 4, 4);
    drain("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
